// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-beat requests to a
// variable-latency instruction memory, buffers one returned word and hands it
// downstream over valid/ready. Redirects discard any in-flight fetch.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect traps into a
// sticky ERROR state (fetch_err_o=1); otherwise the low PC bits are forced to 0.
module instr_fetch_unit #(
  parameter int unsigned                 DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]       PC_RESET   = DATA_WIDTH'(32'h0040_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_o,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [6:0]            opcode_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [31:0]           instr_count_o,
  output logic                  fetch_err_o
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DRAIN = 3'd4
`ifdef FETCH_ALIGN_CHECK_EN
    ,S_ERROR = 3'd5
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] redir_pc;

  // Redirect target as it is loaded into the PC
`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc = redirect_pc_i;
`else
  assign redir_pc = redirect_pc_i & ~DATA_WIDTH'(3);
`endif

  // State and datapath registers; reset aborts any activity immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update; redirect wins over every other event
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = S_DRAIN;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = imem_rvalid_i ? S_FETCH : S_DRAIN;
        end else if (imem_rvalid_i) begin
          buf_d   = imem_rdata_i;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end else if (instr_ready_i) begin
          pc_d    = pc_q + DATA_WIDTH'(4);
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect_i) pc_d = redir_pc;
        if (imem_rvalid_i) state_d = S_FETCH;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_ERROR: state_d = S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect traps; any outstanding response is then ignored
    if (redirect_i && (redirect_pc_i[1:0] != 2'b00) &&
        (state_q != S_IDLE) && (state_q != S_ERROR)) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
    end
`endif
  end

  // Outputs decoded from registered state/data only
  assign imem_req_o    = (state_q == S_FETCH);
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = (state_q == S_VALID);
  assign instr_o       = buf_q;
  assign opcode_o      = buf_q[OPC_W-1:0];
  assign pc_o          = pc_q;
  assign instr_count_o = cnt_q;
  assign fetch_err_o   = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the bench plays the instruction memory.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] instr_count_o;
  logic        fetch_err_o;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .opcode_o      (opcode_o),
    .pc_o          (pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_count_o (instr_count_o),
    .fetch_err_o   (fetch_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in FETCH: expect request at addr, answer after one cycle, accept
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] cnt_after);
    chk("fetch_req", 32'(imem_req_o), 32'd1);
    chk("fetch_addr", imem_addr_o, addr);
    tick();
    chk("wait_noreq", 32'(imem_req_o), 32'd0);
    chk("wait_novalid", 32'(instr_valid_o), 32'd0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    chk("valid", 32'(instr_valid_o), 32'd1);
    chk("instr", instr_o, data);
    chk("opcode", 32'(opcode_o), {25'd0, data[6:0]});
    chk("pc", pc_o, addr);
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("count", instr_count_o, cnt_after);
  endtask

  initial begin
    reset         = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'h0040_0000);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_count", instr_count_o, 32'd0);
    chk("rst_err", 32'(fetch_err_o), 32'd0);

    // IDLE for one cycle, then FETCH
    reset = 1'b0;
    chk("idle_noreq", 32'(imem_req_o), 32'd0);
    tick();

    // Three back-to-back accepts
    fetch_one(32'h0040_0000, 32'h0000_0033, 32'd1);
    fetch_one(32'h0040_0004, 32'h0000_00b3, 32'd2);
    fetch_one(32'h0040_0008, 32'h0000_0133, 32'd3);
    chk("pc_after3", pc_o, 32'h0040_000c);

    // Backpressure: hold ready low for 5 cycles
    chk("bp_req", 32'(imem_req_o), 32'd1);
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_0013;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hffff_ffff;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(instr_valid_o), 32'd1);
      chk("bp_instr", instr_o, 32'h0000_0013);
      chk("bp_noreq", 32'(imem_req_o), 32'd0);
      tick();
    end
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    chk("bp_count", instr_count_o, 32'd4);

    // Redirect in WAIT; stale response arrives 3 cycles later
    chk("rw_addr", imem_addr_o, 32'h0040_0010);
    tick();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    chk("rw_pc", pc_o, 32'h0040_0100);
    for (int i = 0; i < 2; i++) begin
      chk("rw_drain_noreq", 32'(imem_req_o), 32'd0);
      chk("rw_drain_novalid", 32'(instr_valid_o), 32'd0);
      tick();
    end
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hdead_beef;
    tick();
    imem_rvalid_i = 1'b0;
    chk("rw_novalid", 32'(instr_valid_o), 32'd0);
    fetch_one(32'h0040_0100, 32'h0000_0063, 32'd5);

    // Redirect together with ready in VALID: no count, no pc+4
    tick();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_006f;
    tick();
    imem_rvalid_i = 1'b0;
    chk("rv_valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0200;
    tick();
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    chk("rv_count", instr_count_o, 32'd5);
    chk("rv_novalid", 32'(instr_valid_o), 32'd0);
    fetch_one(32'h0040_0200, 32'h0000_0013, 32'd6);

    // Redirect in FETCH, then a second redirect with the orphan response
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0300;
    tick();
    chk("rf_drain_noreq", 32'(imem_req_o), 32'd0);
    chk("rf_pc", pc_o, 32'h0040_0300);
    redirect_pc_i = 32'hffff_fffc;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h1234_5678;
    tick();
    redirect_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    // PC wraps to 0 after accepting the last word of the address space
    fetch_one(32'hffff_fffc, 32'h0000_0037, 32'd7);
    chk("wrap_pc", pc_o, 32'h0000_0000);

    // Misaligned redirect issued in FETCH
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0102;
    tick();
    redirect_i    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("ma_err", 32'(fetch_err_o), 32'd1);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h0000_0033;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0040_0400;
    for (int i = 0; i < 4; i++) begin
      chk("ma_noreq", 32'(imem_req_o), 32'd0);
      chk("ma_novalid", 32'(instr_valid_o), 32'd0);
      chk("ma_sticky", 32'(fetch_err_o), 32'd1);
      tick();
      imem_rvalid_i = 1'b0;
      redirect_i    = 1'b0;
    end
`else
    chk("ma_pc", pc_o, 32'h0040_0100);
    chk("ma_noerr", 32'(fetch_err_o), 32'd0);
    imem_rvalid_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b0;
    fetch_one(32'h0040_0100, 32'h0000_0033, 32'd8);
    tick();
`endif

    // Asynchronous reset mid-operation takes effect without a clock edge
    reset = 1'b1;
    #2;
    chk("arst_pc", pc_o, 32'h0040_0000);
    chk("arst_count", instr_count_o, 32'd0);
    chk("arst_req", 32'(imem_req_o), 32'd0);
    chk("arst_valid", 32'(instr_valid_o), 32'd0);
    chk("arst_err", 32'(fetch_err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential producer of the instruction word, and of the opcode field that feeds the control decoder's OP_i input.
- Holds the PC and issues single-beat requests to a variable-latency instruction memory.
- Buffers one returned instruction and presents it downstream with a valid/ready handshake.
- Accepts PC redirects from branch/jal/jalr resolution and discards any in-flight fetch.

Parameters:
- PC_RESET, 32'h0040_0000, PC value loaded on reset (start of the program text segment).
- DATA_WIDTH, 32, width of PC, addresses and instruction word.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- imem_req_o  output  1  one-cycle request pulse to instruction memory.
- imem_addr_o  output  DATA_WIDTH  fetch address; equals pc_o.
- imem_rvalid_i  input  1  response valid; arrives 1 or more cycles after the request.
- imem_rdata_i  input  DATA_WIDTH  response instruction word.
- instr_valid_o  output  1  buffered instruction available.
- instr_ready_i  input  1  downstream accepts the instruction.
- instr_o  output  DATA_WIDTH  buffered instruction.
- opcode_o  output  7  instr_o[6:0]; drives the control decoder.
- pc_o  output  DATA_WIDTH  PC of the current fetch / buffered instruction.
- redirect_i  input  1  taken branch/jal/jalr; load redirect_pc_i.
- redirect_pc_i  input  DATA_WIDTH  redirect target.
- instr_count_o  output  32  count of accepted instructions.
- fetch_err_o  output  1  misaligned redirect flag (optional feature only).

Behaviour:
- Reset state (asynchronous, active-high):
  - state=IDLE, pc=PC_RESET, buffer=0, instr_count_o=0.
  - imem_req_o=0, instr_valid_o=0, fetch_err_o=0.
- A reset asserted mid-operation aborts everything immediately.
- Instruction memory shares this reset; no stale response is possible after reset.
- States: IDLE, FETCH, WAIT, VALID, DRAIN (plus ERROR with the optional feature).
- IDLE: no outputs asserted; unconditionally goes to FETCH next cycle.
- FETCH:
  - imem_req_o=1 combinationally, imem_addr_o=pc; next state WAIT.
  - imem_rvalid_i is ignored in this state.
- WAIT:
  - On imem_rvalid_i: capture imem_rdata_i into the buffer, go to VALID.
  - Otherwise stay in WAIT; the wait is unbounded.
- VALID:
  - instr_valid_o=1; instr_o, opcode_o and pc_o stay stable until handshake or redirect.
  - On instr_valid_o & instr_ready_i: pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC→0), instr_count_o+=1 (wraps), go to FETCH.
- Best-case latency: request at cycle N, rvalid at N+1, instr_valid_o at N+2; peak throughput is one instruction per 3 cycles.
- redirect_i has priority over all other events in every state except IDLE and ERROR; it always sets pc<=redirect_pc_i.
  - In FETCH: the issued request is orphaned; go to DRAIN.
  - In WAIT without rvalid: go to DRAIN.
  - In WAIT with rvalid the same cycle: drop the data, go to FETCH.
  - In VALID: drop the buffer, instr_valid_o=0 next cycle, go to FETCH. Same-cycle instr_ready_i is ignored: no count, no pc+4.
  - In DRAIN: update pc, stay in DRAIN.
- DRAIN: wait for the orphaned imem_rvalid_i, discard it, go to FETCH. A redirect in the same cycle as that rvalid updates pc and still goes to FETCH.
- Exactly one outstanding memory request at any time.
- imem_req_o is never asserted outside FETCH.
- instr_valid_o is never asserted outside VALID.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Enabled:
  - A redirect with redirect_pc_i[1:0]!=0 goes to ERROR and sets fetch_err_o=1, sticky until reset.
  - In ERROR: no requests, instr_valid_o=0, further redirects are ignored.
  - If a request is outstanding when the error occurs, its response is ignored.
- Disabled:
  - redirect_pc_i[1:0] is forced to 2'b00 when loaded into pc.
  - fetch_err_o is tied 0 and the ERROR state does not exist.

Test Plan:
- Reset release, memory returns 32'h0000_0033 one cycle after the request → req at 0x0040_0000; instr_valid_o two cycles after FETCH; opcode_o=7'h33.
- Three back-to-back accepts with instr_ready_i=1 → addresses 0x0040_0000, 0x0040_0004, 0x0040_0008; instr_count_o=3.
- Hold instr_ready_i=0 for 5 cycles with the memory returning 32'h0000_0013 → instr_o stable at 32'h0000_0013, no new request.
- Redirect to 0x0040_0100 while in WAIT, old response arrives 3 cycles later → old data never presented; next req to 0x0040_0100.
- Redirect to 0x0040_0200 in the same cycle as instr_ready_i in VALID → no count increment; next fetch at 0x0040_0200.
- Optional feature, redirect to 0x0040_0102:
  - Macro on → fetch_err_o=1 and no further requests.
  - Macro off → fetch from 0x0040_0100.
